ram_arb: RTL and testbench

RAM access arbiter for the `dut` 4x2-bit RAM in the `clk` domain. It shares the RAM between two requesters:
- the host port (the ext_* path);
- the debug port, driven by the TAP-side logic after synchronisation into `clk`.

It sequences each access through a small state machine, applies round-robin priority, and lets the debug side lock out the host during boundary-scan test. It is the single owner of `ram_wr`, `ram_addr` and `ram_din`.

---
 rtl/ram_arb.sv | 173 +++++++++++++++++
 tb/tb_ram_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: shares a small RAM between a host port and a debug port.
// Each access runs IDLE -> ACCESS -> RESP. Ties go round-robin, and the
// debug side can lock the host out of new grants. All outputs are registered.
//
// Handshake: a requester raises req with wr/addr/din and holds all of them
// stable until it sees its one-cycle ack. The arbiter samples wr/addr/din only
// on the IDLE->ACCESS edge. A req still high in the cycle after ack counts as
// a new request.
module ram_arb #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 2,
    parameter int AWIDTH  = $clog2(DEPTH),
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               h_req,
    input  logic               h_wr,
    input  logic [AWIDTH-1:0]  h_addr,
    input  logic [WIDTH-1:0]   h_din,
    output logic               h_ack,
    output logic [WIDTH-1:0]   h_dout,
    input  logic               d_req,
    input  logic               d_wr,
    input  logic [AWIDTH-1:0]  d_addr,
    input  logic [WIDTH-1:0]   d_din,
    output logic               d_ack,
    output logic [WIDTH-1:0]   d_dout,
    input  logic               d_lock,
    output logic               ram_wr,
    output logic [AWIDTH-1:0]  ram_addr,
    output logic [WIDTH-1:0]   ram_din,
    input  logic [WIDTH-1:0]   ram_dout,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cnt,
    input  logic               clr_stall,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    state_t               r_state, w_state_nxt;
    logic                 r_owner_dbg, w_owner_dbg_nxt;   // owner of the access in flight
    logic                 r_last_dbg, w_last_dbg_nxt;     // 1: debug was granted last
    logic                 r_h_ack, w_h_ack_nxt;
    logic                 r_d_ack, w_d_ack_nxt;
    logic [WIDTH-1:0]     r_h_dout, w_h_dout_nxt;
    logic [WIDTH-1:0]     r_d_dout, w_d_dout_nxt;
    logic                 r_ram_wr, w_ram_wr_nxt;
    logic [AWIDTH-1:0]    r_ram_addr, w_ram_addr_nxt;
    logic [WIDTH-1:0]     r_ram_din, w_ram_din_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [STALL_W-1:0]   r_stall_cnt, w_stall_cnt_nxt;

    logic w_h_elig, w_d_elig, w_grant_h, w_grant_d, w_h_served;

    assign w_h_elig  = h_req & ~d_lock;
    assign w_d_elig  = d_req;
    // On a tie, debug wins unless it was the last one granted.
    assign w_grant_d = (r_state == S_IDLE) & w_d_elig & (~w_h_elig | ~r_last_dbg);
    assign w_grant_h = (r_state == S_IDLE) & w_h_elig & ~w_grant_d;
    // The host is not stalling while it is being granted or is the owner in flight.
    assign w_h_served = (r_state == S_IDLE) ? w_grant_h : ~r_owner_dbg;

    // Next-state and next-output computation for the access sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_dbg_nxt = r_owner_dbg;
        w_last_dbg_nxt  = r_last_dbg;
        w_h_ack_nxt     = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_h_dout_nxt    = r_h_dout;
        w_d_dout_nxt    = r_d_dout;
        w_ram_wr_nxt    = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_din_nxt   = r_ram_din;
        w_stall_cnt_nxt = r_stall_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt     = S_ACCESS;
                    w_owner_dbg_nxt = 1'b1;
                    w_last_dbg_nxt  = 1'b1;
                    w_ram_wr_nxt    = d_wr;
                    w_ram_addr_nxt  = d_addr;
                    w_ram_din_nxt   = d_din;
                end else if (w_grant_h) begin
                    w_state_nxt     = S_ACCESS;
                    w_owner_dbg_nxt = 1'b0;
                    w_last_dbg_nxt  = 1'b0;
                    w_ram_wr_nxt    = h_wr;
                    w_ram_addr_nxt  = h_addr;
                    w_ram_din_nxt   = h_din;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
                // r_ram_wr is high in ACCESS exactly when this access is a write.
                if (!r_ram_wr) begin
                    if (r_owner_dbg) w_d_dout_nxt = ram_dout;
                    else             w_h_dout_nxt = ram_dout;
                end
                if (r_owner_dbg) w_d_ack_nxt = 1'b1;
                else             w_h_ack_nxt = 1'b1;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);

        if (clr_stall) begin
            w_stall_cnt_nxt = '0;
        end else if (h_req && !w_h_served && (r_stall_cnt != STALL_MAX)) begin
            w_stall_cnt_nxt = r_stall_cnt + STALL_ONE;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_dbg <= 1'b0;
            r_last_dbg  <= 1'b0;
            r_h_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_h_dout    <= '0;
            r_d_dout    <= '0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_busy      <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner_dbg <= w_owner_dbg_nxt;
            r_last_dbg  <= w_last_dbg_nxt;
            r_h_ack     <= w_h_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_h_dout    <= w_h_dout_nxt;
            r_d_dout    <= w_d_dout_nxt;
            r_ram_wr    <= w_ram_wr_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_din   <= w_ram_din_nxt;
            r_busy      <= w_busy_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign h_ack     = r_h_ack;
    assign d_ack     = r_d_ack;
    assign h_dout    = r_h_dout;
    assign d_dout    = r_d_dout;
    assign ram_wr    = r_ram_wr;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign busy      = r_busy;
    assign stall_cnt = r_stall_cnt;
    assign o_state   = r_state;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of the arbitration rules.
module tb_ram_arb;

    localparam int DEPTH   = 4;
    localparam int WIDTH   = 2;
    localparam int AWIDTH  = 2;
    localparam int STALL_W = 8;
    localparam int SMAX    = (1 << STALL_W) - 1;

    logic              clk, rst_n;
    logic              h_req, h_wr, d_req, d_wr, d_lock, clr_stall;
    logic [AWIDTH-1:0] h_addr, d_addr;
    logic [WIDTH-1:0]  h_din, d_din;
    logic              h_ack, d_ack, ram_wr, busy;
    logic [WIDTH-1:0]  h_dout, d_dout, ram_din, ram_dout;
    logic [AWIDTH-1:0] ram_addr;
    logic [STALL_W-1:0] stall_cnt;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    ram_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AWIDTH(AWIDTH), .STALL_W(STALL_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_din(h_din),
        .h_ack(h_ack), .h_dout(h_dout),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_din(d_din),
        .d_ack(d_ack), .d_dout(d_dout),
        .d_lock(d_lock),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .stall_cnt(stall_cnt), .clr_stall(clr_stall),
        .o_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM attached to the arbiter: synchronous write, asynchronous read
    logic [WIDTH-1:0] ram_mem [DEPTH] = '{default: '0};
    always @(posedge clk) if (ram_wr) ram_mem[ram_addr] <= ram_din;
    assign ram_dout = ram_mem[ram_addr];

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 RAM access, 2 response
    int               m_phase;
    bit               m_owner;   // 1 = debug
    bit               m_last;    // 1 = debug granted last
    bit               m_wr;
    logic [AWIDTH-1:0] m_addr;
    logic [WIDTH-1:0]  m_din, m_hdout, m_ddout;
    int               m_stall;
    logic [WIDTH-1:0]  m_mem [DEPTH];
    logic [WIDTH:0]    exp_q [$];   // {port_is_debug, dout seen with the ack}

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = 0; m_wr = 0;
        m_addr = '0; m_din = '0; m_hdout = '0; m_ddout = '0; m_stall = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit he, de, gh, gd, host_busy;
        he = h_req && !d_lock;
        de = d_req;
        gh = 0; gd = 0;
        if (m_phase == 0) begin
            if (he && de) begin
                if (m_last) gh = 1; else gd = 1;
            end else if (he) gh = 1;
            else if (de) gd = 1;
        end
        host_busy = gh || (m_phase != 0 && !m_owner);
        if (clr_stall) m_stall = 0;
        else if (h_req && !host_busy && m_stall < SMAX) m_stall = m_stall + 1;
        case (m_phase)
            0: if (gh || gd) begin
                m_owner = gd; m_last = gd;
                m_wr   = gd ? d_wr : h_wr;
                m_addr = gd ? d_addr : h_addr;
                m_din  = gd ? d_din : h_din;
                m_phase = 1;
            end
            1: begin
                if (m_wr) m_mem[m_addr] = m_din;
                else if (m_owner) m_ddout = m_mem[m_addr];
                else m_hdout = m_mem[m_addr];
                exp_q.push_back({m_owner, m_owner ? m_ddout : m_hdout});
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [WIDTH:0] item;
        check("ram_wr",    32'(ram_wr),    32'(m_phase == 1 && m_wr));
        check("ram_addr",  32'(ram_addr),  32'(m_addr));
        check("ram_din",   32'(ram_din),   32'(m_din));
        check("h_ack",     32'(h_ack),     32'(m_phase == 2 && !m_owner));
        check("d_ack",     32'(d_ack),     32'(m_phase == 2 && m_owner));
        check("h_dout",    32'(h_dout),    32'(m_hdout));
        check("d_dout",    32'(d_dout),    32'(m_ddout));
        check("busy",      32'(busy),      32'(m_phase != 0));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (h_ack || d_ack) begin
            if (exp_q.size() == 0) check("ack_unexpected", 32'(1), 32'(0));
            else begin
                item = exp_q.pop_front();
                check("ack_sb", 32'({d_ack, d_ack ? d_dout : h_dout}), 32'(item));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        h_req = 0; h_wr = 0; h_addr = '0; h_din = '0;
        d_req = 0; d_wr = 0; d_addr = '0; d_din = '0;
        d_lock = 0; clr_stall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_ram_wr",32'(ram_wr),    32'(0));
        check("rst_acks",  32'({h_ack, d_ack}), 32'(0));
        check("rst_addr",  32'(ram_addr),  32'(0));
        check("rst_din",   32'(ram_din),   32'(0));
        check("rst_douts", 32'({h_dout, d_dout}), 32'(0));
        check("rst_stall", 32'(stall_cnt), 32'(0));
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input bit dbg, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (dbg ? d_ack : h_ack) return;
        end
        check("ack_timeout", 32'(0), 32'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, wr_cnt, d_at, h_at, seen, nacks;
        logic [3:0] ord;
        logic [7:0] rst_regs;

        // reset values
        do_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        step();

        // host write then read
        h_wr = 1; h_addr = 2; h_din = 2'b10; h_req = 1;
        wr_cnt = 0; n = 0;
        for (int i = 0; i < 10; i++) begin
            step(); n++;
            if (ram_wr) wr_cnt++;
            if (h_ack) break;
        end
        check("wr_latency", 32'(n), 32'(2));
        h_req = 0;
        step();
        if (ram_wr) wr_cnt++;
        check("wr_pulse", 32'(wr_cnt), 32'(1));
        h_wr = 0; h_req = 1;
        wait_ack(0, n);
        check("rd_latency", 32'(n), 32'(2));
        check("rd_data", 32'(h_dout), 32'(2'b10));
        h_req = 0;
        step();

        // tie right after reset: debug first
        do_reset();
        h_req = 1; h_wr = 0; h_addr = 1;
        d_req = 1; d_wr = 1; d_addr = 3; d_din = 2'b01;
        d_at = 0; h_at = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (d_ack) begin d_at = i; d_req = 0; end
            if (h_ack) begin h_at = i; h_req = 0; check("tie_stall", 32'(stall_cnt), 32'(3)); end
        end
        check("tie_d_at", 32'(d_at), 32'(2));
        check("tie_h_at", 32'(h_at), 32'(5));

        // lock holds host off
        do_reset();
        d_lock = 1; h_req = 1; h_wr = 0; h_addr = 0;
        seen = 0;
        repeat (10) begin
            step();
            if (h_ack) seen++;
        end
        check("lock_noack", 32'(seen), 32'(0));
        check("lock_stall", 32'(stall_cnt), 32'(10));
        d_lock = 0;
        step();
        check("lock_grant", 32'(busy), 32'(1));
        wait_ack(0, n);
        h_req = 0;
        step();

        // continuous contention
        do_reset();
        h_req = 1; h_wr = 0; h_addr = 1;
        d_req = 1; d_wr = 0; d_addr = 3;
        ord = '0; nacks = 0;
        repeat (12) begin
            step();
            if (d_ack) begin ord = {ord[2:0], 1'b1}; nacks++; end
            if (h_ack) begin ord = {ord[2:0], 1'b0}; nacks++; end
        end
        h_req = 0; d_req = 0;
        repeat (3) step();
        check("cont_nacks", 32'(nacks), 32'(4));
        check("cont_order", 32'(ord), 32'(4'b1010));

        // reset during a host read's ACCESS
        do_reset();
        h_req = 1; h_wr = 0; h_addr = 2;
        step();
        check("mid_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        rst_regs = {busy, ram_wr, h_ack, d_ack, ram_addr, h_dout};
        check("mid_rst_regs", 32'(rst_regs), 32'(0));
        check("mid_rst_stall", 32'(stall_cnt), 32'(0));
        model_reset();
        h_req = 0;
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (h_ack) seen++;
        end
        check("mid_no_ack", 32'(seen), 32'(0));

        // stall counter saturation and clear
        do_reset();
        d_lock = 1; h_req = 1;
        repeat (300) step();
        check("sat_255", 32'(stall_cnt), 32'(255));
        clr_stall = 1;
        step();
        check("clr_zero", 32'(stall_cnt), 32'(0));
        clr_stall = 0;
        step();
        check("clr_then_one", 32'(stall_cnt), 32'(1));
        h_req = 0; d_lock = 0;
        step();

        // randomized traffic
        do_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = ram_mem[i];
        for (int cyc = 0; cyc < 500; cyc++) begin
            bit h_done, d_done;
            step();
            h_done = (m_phase == 2 && !m_owner);
            d_done = (m_phase == 2 && m_owner);
            if ((h_done || !h_req) && $urandom_range(0, 2) == 0) begin
                h_req = 1; h_wr = 1'($urandom_range(0, 1));
                h_addr = AWIDTH'($urandom_range(0, DEPTH - 1));
                h_din = WIDTH'($urandom_range(0, 3));
            end else if (h_done) h_req = 0;
            if ((d_done || !d_req) && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_wr = 1'($urandom_range(0, 1));
                d_addr = AWIDTH'($urandom_range(0, DEPTH - 1));
                d_din = WIDTH'($urandom_range(0, 3));
            end else if (d_done) d_req = 0;
            if ($urandom_range(0, 15) == 0) d_lock = ~d_lock;
            clr_stall = ($urandom_range(0, 30) == 0);
        end
        h_req = 0; d_req = 0; d_lock = 0; clr_stall = 0;
        repeat (6) step();
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
